eic_core_responder: RTL and testbench

- Core-side end of the EIC interface; mirrors the MIPS microAptiv interrupt acceptance logic.
- Consumes EIC_Interrupt/EIC_Vector/EIC_Offset/EIC_ShadowSet from the eic block.
- Decides when a request is taken and returns SI_IAck/SI_IPL/SI_IVN/SI_ION to the eic.
- Keeps a nesting stack of interrupted priority levels; drives a take pulse plus handler target to the core/testbench.

---
 rtl/eic_pkg.sv | 38 +++
 rtl/eic_ipl_stack.sv | 48 ++++
 rtl/eic_core_responder.sv | 168 ++++++++++++++++
 tb/tb_eic_core_responder.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eic_pkg.sv
// Shared definitions for the core-side EIC responder: FSM encoding,
// field widths and the default handler vector base.
package eic_pkg;

    localparam int IPL_W = 8;
    localparam int IVN_W = 6;
    localparam int ION_W = 17;
    localparam int OFF_W = 18;

    localparam logic [OFF_W-1:0] VECTOR_BASE = 18'h200;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_QUAL  = 2'd1,
        ST_ACK   = 2'd2,
        ST_GUARD = 2'd3
    } eic_state_t;

    // Handler byte offset: either the eic-supplied offset (bit 0 forced to 0)
    // or base + vector * spacing, truncated to 18 bits.
    function automatic logic [OFF_W-1:0] calc_offset(
        input logic             use_offset,
        input logic [ION_W-1:0] offset,
        input logic [IVN_W-1:0] vector,
        input int               spacing
    );
        logic [OFF_W-1:0] vec_ext;
        logic [OFF_W-1:0] sp;
        vec_ext = {{(OFF_W-IVN_W){1'b0}}, vector};
        sp      = OFF_W'(spacing);
        if (use_offset) begin
            calc_offset = {offset, 1'b0};
        end else begin
            calc_offset = VECTOR_BASE + vec_ext * sp;
        end
    endfunction

endpackage

// File: rtl/eic_ipl_stack.sv
// LIFO of interrupted priority levels. A simultaneous push and pop leaves
// the contents and count untouched (the pushed value is the one popped),
// so dout keeps showing the previous top.
module eic_ipl_stack
    import eic_pkg::*;
#(
    parameter int NEST_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [IPL_W-1:0] din,
    output logic [IPL_W-1:0] dout,
    output logic [3:0]       count,
    output logic             empty,
    output logic             full
);

    // Storage is always 8 entries; NEST_DEPTH only limits how many are used.
    logic [IPL_W-1:0] mem [8];
    logic [3:0]       top_idx;

    assign empty   = (count == 4'd0);
    assign full    = (count == 4'(NEST_DEPTH));
    assign top_idx = count - 4'd1;
    assign dout    = empty ? '0 : mem[top_idx[2:0]];

    // Push writes above the current top; pop only moves the count down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !pop) begin
            if (!full) begin
                mem[count[2:0]] <= din;
                count           <= count + 4'd1;
            end
        end else if (pop && !push) begin
            if (!empty) begin
                count <= count - 4'd1;
            end
        end
    end

endmodule

// File: rtl/eic_core_responder.sv
// Core-side EIC responder: qualifies requests above the current IPL,
// acknowledges them, stacks the interrupted level and returns the handler
// target. cpu_eret restores the previous level from the stack.
//
// Handshake: a take is a single-cycle pulse (SI_IAck == irq_take) issued
// from the ACK state; there is no back-pressure, the eic must accept it.
// After a take the request inputs are ignored for GUARD_CYCLES cycles.
module eic_core_responder
    import eic_pkg::*;
#(
    parameter int NEST_DEPTH     = 4,
    parameter int QUAL_CYCLES    = 1,
    parameter int GUARD_CYCLES   = 2,
    parameter bit USE_OFFSET     = 1'b0,
    parameter int VECTOR_SPACING = 32
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic [IPL_W-1:0] EIC_Interrupt,
    input  logic [IVN_W-1:0] EIC_Vector,
    input  logic [ION_W-1:0] EIC_Offset,
    input  logic [3:0]       EIC_ShadowSet,
    input  logic             cpu_ie,
    input  logic             cpu_eret,
    output logic             SI_IAck,
    output logic [IPL_W-1:0] SI_IPL,
    output logic [IVN_W-1:0] SI_IVN,
    output logic [ION_W-1:0] SI_ION,
    output logic             irq_take,
    output logic [OFF_W-1:0] irq_offset,
    output logic [3:0]       irq_shadowset,
    output logic [3:0]       nest_level,
    output logic             err_underflow
);

    localparam logic [2:0] QUAL_LAST  = 3'(QUAL_CYCLES);
    localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES - 1);

    // FSM state is kept visible under a plain name for probing.
    eic_state_t       state, state_next;
    logic [2:0]       qcnt, qcnt_next;
    logic [7:0]       gcnt, gcnt_next;
    logic [IPL_W-1:0] req_lvl, req_lvl_next;

    logic             take;
    logic             eligible;
    logic [IPL_W-1:0] stk_dout;
    logic [3:0]       stk_count;
    logic             stk_empty;
    logic             stk_full;
    logic [OFF_W-1:0] off_calc;
    logic [OFF_W-1:0] off_q;

    assign take     = (state == ST_ACK);
    assign SI_IAck  = take;
    assign irq_take = take;
    assign eligible = cpu_ie && (EIC_Interrupt > SI_IPL) && !stk_full;
    assign off_calc = calc_offset(USE_OFFSET, EIC_Offset, EIC_Vector, VECTOR_SPACING);
    // Offset is presented during the take cycle and held afterwards.
    assign irq_offset = take ? off_calc : off_q;
    assign nest_level = stk_count;

    eic_ipl_stack #(
        .NEST_DEPTH(NEST_DEPTH)
    ) u_stack (
        .clk   (CLK),
        .rst_n (RESETn),
        .push  (take),
        .pop   (cpu_eret),
        .din   (SI_IPL),
        .dout  (stk_dout),
        .count (stk_count),
        .empty (stk_empty),
        .full  (stk_full)
    );

    // FSM state and counter registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state   <= ST_READY;
            qcnt    <= 3'd0;
            gcnt    <= 8'd0;
            req_lvl <= '0;
        end else begin
            state   <= state_next;
            qcnt    <= qcnt_next;
            gcnt    <= gcnt_next;
            req_lvl <= req_lvl_next;
        end
    end

    // Next-state: qualify a stable eligible request, ack it, then guard.
    always_comb begin
        state_next   = state;
        qcnt_next    = qcnt;
        gcnt_next    = gcnt;
        req_lvl_next = req_lvl;
        case (state)
            ST_READY: begin
                if (eligible) begin
                    if (QUAL_CYCLES == 0) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next   = ST_QUAL;
                        qcnt_next    = 3'd1;
                        req_lvl_next = EIC_Interrupt;
                    end
                end
            end
            ST_QUAL: begin
                // A return changes SI_IPL, so restart qualification from READY.
                if (!eligible || (EIC_Interrupt != req_lvl) || cpu_eret) begin
                    state_next = ST_READY;
                end else if (qcnt == QUAL_LAST) begin
                    state_next = ST_ACK;
                end else begin
                    qcnt_next = qcnt + 3'd1;
                end
            end
            ST_ACK: begin
                gcnt_next = 8'd0;
                if (GUARD_CYCLES == 0) begin
                    state_next = ST_READY;
                end else begin
                    state_next = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (gcnt == GUARD_LAST) begin
                    state_next = ST_READY;
                end else begin
                    gcnt_next = gcnt + 8'd1;
                end
            end
            default: state_next = ST_READY;
        endcase
    end

    // In-service level, handler target latches and sticky underflow flag.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            SI_IPL        <= '0;
            SI_IVN        <= '0;
            SI_ION        <= '0;
            irq_shadowset <= 4'd0;
            off_q         <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (take) begin
                SI_IVN        <= EIC_Vector;
                SI_ION        <= EIC_Offset;
                irq_shadowset <= EIC_ShadowSet;
                off_q         <= off_calc;
                // Return in the take cycle pops the level just pushed.
                if (!cpu_eret) begin
                    SI_IPL <= EIC_Interrupt;
                end
            end else if (cpu_eret) begin
                if (stk_empty) begin
                    err_underflow <= 1'b1;
                end else begin
                    SI_IPL <= stk_dout;
                end
            end
        end
    end

endmodule

// File: tb/tb_eic_core_responder.sv
// Directed bench for eic_core_responder. Instance a: QUAL=1, computed
// vectors. Instance b: QUAL=2, eic-supplied offsets. Both share inputs.
module tb_eic_core_responder;

    logic        CLK;
    logic        RESETn;
    logic [7:0]  EIC_Interrupt;
    logic [5:0]  EIC_Vector;
    logic [16:0] EIC_Offset;
    logic [3:0]  EIC_ShadowSet;
    logic        cpu_ie;
    logic        cpu_eret;

    logic        a_iack, a_take, a_err;
    logic [7:0]  a_ipl;
    logic [5:0]  a_ivn;
    logic [16:0] a_ion;
    logic [17:0] a_off;
    logic [3:0]  a_ss, a_nest;

    logic        b_iack, b_take, b_err;
    logic [7:0]  b_ipl;
    logic [5:0]  b_ivn;
    logic [16:0] b_ion;
    logic [17:0] b_off;
    logic [3:0]  b_ss, b_nest;

    int errors = 0;
    int checks = 0;

    eic_core_responder #(
        .NEST_DEPTH(4), .QUAL_CYCLES(1), .GUARD_CYCLES(2),
        .USE_OFFSET(1'b0), .VECTOR_SPACING(32)
    ) dut_a (
        .CLK(CLK), .RESETn(RESETn), .EIC_Interrupt(EIC_Interrupt),
        .EIC_Vector(EIC_Vector), .EIC_Offset(EIC_Offset),
        .EIC_ShadowSet(EIC_ShadowSet), .cpu_ie(cpu_ie), .cpu_eret(cpu_eret),
        .SI_IAck(a_iack), .SI_IPL(a_ipl), .SI_IVN(a_ivn), .SI_ION(a_ion),
        .irq_take(a_take), .irq_offset(a_off), .irq_shadowset(a_ss),
        .nest_level(a_nest), .err_underflow(a_err)
    );

    eic_core_responder #(
        .NEST_DEPTH(4), .QUAL_CYCLES(2), .GUARD_CYCLES(2),
        .USE_OFFSET(1'b1), .VECTOR_SPACING(32)
    ) dut_b (
        .CLK(CLK), .RESETn(RESETn), .EIC_Interrupt(EIC_Interrupt),
        .EIC_Vector(EIC_Vector), .EIC_Offset(EIC_Offset),
        .EIC_ShadowSet(EIC_ShadowSet), .cpu_ie(cpu_ie), .cpu_eret(cpu_eret),
        .SI_IAck(b_iack), .SI_IPL(b_ipl), .SI_IVN(b_ivn), .SI_ION(b_ion),
        .irq_take(b_take), .irq_offset(b_off), .irq_shadowset(b_ss),
        .nest_level(b_nest), .err_underflow(b_err)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input logic [7:0] lvl, input logic [5:0] vec,
                           input logic [16:0] off, input logic [3:0] ss);
        EIC_Interrupt = lvl;
        EIC_Vector    = vec;
        EIC_Offset    = off;
        EIC_ShadowSet = ss;
    endtask

    task automatic do_reset();
        RESETn = 1'b0;
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
        cpu_ie   = 1'b0;
        cpu_eret = 1'b0;
        tick();
        tick();
        RESETn = 1'b1;
        tick();
    endtask

    task automatic pulse_eret();
        cpu_eret = 1'b1;
        tick();
        cpu_eret = 1'b0;
    endtask

    // Returns the number of ticks until the selected ack is seen, or -1.
    task automatic wait_ack(input bit use_b, input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if ((use_b ? b_iack : a_iack) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Counts acks of the selected instance over a number of ticks.
    task automatic count_acks(input bit use_b, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if ((use_b ? b_iack : a_iack) === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
        cpu_ie   = 1'b0;
        cpu_eret = 1'b0;
        tick();
        tick();
        checks++;
        if ({a_iack, a_take, a_ipl, a_ivn, a_ion, a_off, a_ss, a_nest, a_err} !== 67'd0) begin
            errors++;
            $display("FAIL reset_a: outputs=%h expected 0",
                     {a_iack, a_take, a_ipl, a_ivn, a_ion, a_off, a_ss, a_nest, a_err});
        end
        checks++;
        if ({b_iack, b_take, b_ipl, b_ivn, b_ion, b_off, b_ss, b_nest, b_err} !== 67'd0) begin
            errors++;
            $display("FAIL reset_b: outputs=%h expected 0",
                     {b_iack, b_take, b_ipl, b_ivn, b_ion, b_off, b_ss, b_nest, b_err});
        end
        RESETn = 1'b1;
        tick();
    endtask

    task automatic test_basic_take();
        cpu_ie = 1'b1;
        set_req(8'd3, 6'd5, 17'd0, 4'd2);
        tick();
        checks++;
        if (a_iack !== 1'b0) begin
            errors++; $display("FAIL take_early: iack=%b expected 0", a_iack);
        end
        tick();
        checks++;
        if ({a_iack, a_take} !== 2'b11) begin
            errors++; $display("FAIL take_pulse: iack,take=%b expected 11", {a_iack, a_take});
        end
        checks++;
        if (a_off !== 18'h002A0) begin
            errors++; $display("FAIL take_offset_live: offset=%h expected 002a0", a_off);
        end
        tick();
        checks++;
        if (a_iack !== 1'b0 || a_ipl !== 8'd3 || a_ivn !== 6'd5 || a_nest !== 4'd1 ||
            a_off !== 18'h002A0 || a_ss !== 4'd2) begin
            errors++;
            $display("FAIL take_latched: iack=%b ipl=%0d ivn=%0d nest=%0d off=%h ss=%0d expected 0 3 5 1 002a0 2",
                     a_iack, a_ipl, a_ivn, a_nest, a_off, a_ss);
        end
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
    endtask

    task automatic test_nesting();
        int n;
        set_req(8'd2, 6'd1, 17'd0, 4'd0);
        count_acks(1'b0, 8, n);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL lower_level: acks=%0d expected 0", n);
        end
        set_req(8'd7, 6'd9, 17'd0, 4'd1);
        wait_ack(1'b0, 12, n);
        checks++;
        if (n < 0 || a_off !== 18'h00320) begin
            errors++; $display("FAIL nest_take: wait=%0d off=%h expected ack with 00320", n, a_off);
        end
        tick();
        checks++;
        if (a_ipl !== 8'd7 || a_nest !== 4'd2 || a_ivn !== 6'd9) begin
            errors++;
            $display("FAIL nest_state: ipl=%0d nest=%0d ivn=%0d expected 7 2 9", a_ipl, a_nest, a_ivn);
        end
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
        pulse_eret();
        checks++;
        if (a_ipl !== 8'd3 || a_nest !== 4'd1) begin
            errors++; $display("FAIL eret_1: ipl=%0d nest=%0d expected 3 1", a_ipl, a_nest);
        end
        pulse_eret();
        checks++;
        if (a_ipl !== 8'd0 || a_nest !== 4'd0 || a_err !== 1'b0) begin
            errors++;
            $display("FAIL eret_2: ipl=%0d nest=%0d err=%b expected 0 0 0", a_ipl, a_nest, a_err);
        end
    endtask

    task automatic test_stack_full();
        int n;
        for (int lvl = 1; lvl <= 4; lvl++) begin
            set_req(8'(lvl), 6'(lvl), 17'd0, 4'd0);
            wait_ack(1'b0, 12, n);
            checks++;
            if (n < 0) begin
                errors++; $display("FAIL fill_take: level=%0d no ack within 12 cycles", lvl);
            end
            tick();
        end
        checks++;
        if (a_ipl !== 8'd4 || a_nest !== 4'd4) begin
            errors++; $display("FAIL full_state: ipl=%0d nest=%0d expected 4 4", a_ipl, a_nest);
        end
        set_req(8'd5, 6'd5, 17'd0, 4'd0);
        count_acks(1'b0, 8, n);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL full_block: acks=%0d expected 0", n);
        end
        pulse_eret();
        checks++;
        if (a_ipl !== 8'd3 || a_nest !== 4'd3) begin
            errors++; $display("FAIL full_eret: ipl=%0d nest=%0d expected 3 3", a_ipl, a_nest);
        end
        wait_ack(1'b0, 12, n);
        checks++;
        if (n < 0) begin
            errors++; $display("FAIL pended_take: no ack within 12 cycles, expected one");
        end
        tick();
        checks++;
        if (a_ipl !== 8'd5 || a_nest !== 4'd4) begin
            errors++; $display("FAIL pended_state: ipl=%0d nest=%0d expected 5 4", a_ipl, a_nest);
        end
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
    endtask

    task automatic test_qualify();
        int n;
        do_reset();
        cpu_ie = 1'b1;
        set_req(8'd4, 6'd2, 17'd0, 4'd0);
        tick();
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
        count_acks(1'b1, 8, n);
        checks++;
        if (n !== 0) begin
            errors++; $display("FAIL glitch_req: acks=%0d expected 0", n);
        end
        cpu_ie = 1'b0;
        set_req(8'd6, 6'd3, 17'd0, 4'd0);
        count_acks(1'b1, 8, n);
        checks++;
        if (n !== 0 || b_ipl !== 8'd0) begin
            errors++; $display("FAIL ie_off: acks=%0d ipl=%0d expected 0 0", n, b_ipl);
        end
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
    endtask

    task automatic test_offset_guard();
        int n;
        do_reset();
        cpu_ie = 1'b1;
        set_req(8'd3, 6'd1, 17'h00400, 4'hA);
        tick();
        tick();
        checks++;
        if (b_iack !== 1'b0) begin
            errors++; $display("FAIL qual2_early: iack=%b expected 0", b_iack);
        end
        tick();
        checks++;
        if (b_iack !== 1'b1 || b_off !== 18'h00800) begin
            errors++; $display("FAIL qual2_take: iack=%b off=%h expected 1 00800", b_iack, b_off);
        end
        tick();
        checks++;
        if (b_ipl !== 8'd3 || b_ion !== 17'h00400 || b_ss !== 4'hA || b_off !== 18'h00800) begin
            errors++;
            $display("FAIL offset_latched: ipl=%0d ion=%h ss=%h off=%h expected 3 00400 a 00800",
                     b_ipl, b_ion, b_ss, b_off);
        end
        set_req(8'd6, 6'd1, 17'h00400, 4'hA);
        wait_ack(1'b1, 12, n);
        checks++;
        if (n + 1 !== 6) begin
            errors++; $display("FAIL guard_gap: ack gap=%0d expected 6", n + 1);
        end
        tick();
        checks++;
        if (b_ipl !== 8'd6 || b_nest !== 4'd2) begin
            errors++; $display("FAIL guard_take: ipl=%0d nest=%0d expected 6 2", b_ipl, b_nest);
        end
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
    endtask

    task automatic test_underflow_reset();
        int n;
        do_reset();
        cpu_ie = 1'b1;
        pulse_eret();
        checks++;
        if (a_err !== 1'b1 || a_ipl !== 8'd0 || a_nest !== 4'd0) begin
            errors++;
            $display("FAIL underflow: err=%b ipl=%0d nest=%0d expected 1 0 0", a_err, a_ipl, a_nest);
        end
        set_req(8'd5, 6'd4, 17'd0, 4'd0);
        tick();
        RESETn = 1'b0;
        #1;
        checks++;
        if (a_iack !== 1'b0 || b_iack !== 1'b0 || a_err !== 1'b0 || b_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: iack=%b%b err=%b%b expected 00 00", a_iack, b_iack, a_err, b_err);
        end
        count_acks(1'b0, 2, n);
        checks++;
        if (n !== 0 || b_iack !== 1'b0) begin
            errors++; $display("FAIL reset_hold: acks=%0d b_iack=%b expected 0 0", n, b_iack);
        end
        set_req(8'd0, 6'd0, 17'd0, 4'd0);
        RESETn = 1'b1;
        count_acks(1'b1, 4, n);
        checks++;
        if (n !== 0 || a_err !== 1'b0 || a_ipl !== 8'd0) begin
            errors++;
            $display("FAIL post_reset: acks=%0d err=%b ipl=%0d expected 0 0 0", n, a_err, a_ipl);
        end
    endtask

    initial begin
        test_reset();
        test_basic_take();
        test_nesting();
        test_stack_full();
        test_qualify();
        test_offset_guard();
        test_underflow_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
